// File: rtl/button_conditioner.sv
// Button front end: synchronizes and debounces three raw buttons, then turns
// them into single-cycle move/drop commands with left/right hold-to-repeat.

module bc_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 24,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_db_nxt,
    output logic o_rise
);
    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             w_db_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // The counter only advances while s2 disagrees with the filtered state.
    always_comb begin
        w_db_nxt  = r_db;
        w_cnt_nxt = '0;
        if (r_s2 != r_db) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1))
                w_db_nxt = r_s2;
            else
                w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_raw ^ ACTIVE_LOW;
            r_s2  <= r_s1;
            r_db  <= w_db_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_db_nxt = w_db_nxt;
    assign o_rise   = w_db_nxt & ~r_db;
endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 3750000,
    parameter int CNT_W           = 24,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk_25MHz,
    input  logic rst_n,
    input  logic btn_right_raw,
    input  logic btn_left_raw,
    input  logic btn_drop_raw,
    output logic move_right,
    output logic move_left,
    output logic drop_piece
);
    localparam int NUM_CH = 3;
    localparam int CH_R   = 0;
    localparam int CH_L   = 1;
    localparam int CH_D   = 2;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCKED} state_t;

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_db_nxt;
    logic [NUM_CH-1:0] w_rise;

    assign w_raw = {btn_drop_raw, btn_left_raw, btn_right_raw};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        bc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_db (
            .i_clk   (clk_25MHz),
            .i_rst_n (rst_n),
            .i_raw   (w_raw[ch]),
            .o_db_nxt(w_db_nxt[ch]),
            .o_rise  (w_rise[ch])
        );
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_dir;        // 1 = left is the held direction
    logic             w_dir_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] w_limit;
    logic             w_held;
    logic             w_opp;
    logic             w_pulse_r;
    logic             w_pulse_l;

    // Decisions use the debounced values as they will be after this edge, so
    // a pulse lands on the same edge the debounced state flips.
    assign w_held  = r_dir ? w_db_nxt[CH_L] : w_db_nxt[CH_R];
    assign w_opp   = r_dir ? w_db_nxt[CH_R] : w_db_nxt[CH_L];
    assign w_limit = (r_state == DELAY) ? CNT_W'(REPEAT_DELAY - 1)
                                        : CNT_W'(REPEAT_PERIOD - 1);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        w_pulse_r   = 1'b0;
        w_pulse_l   = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (w_db_nxt[CH_L] && w_db_nxt[CH_R]) begin
                    w_state_nxt = LOCKED;
                end else if (w_rise[CH_L]) begin
                    w_pulse_l   = 1'b1;
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = DELAY;
                end else if (w_rise[CH_R]) begin
                    w_pulse_r   = 1'b1;
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!w_held) begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else if (w_opp) begin
                    w_state_nxt = LOCKED;
                    w_timer_nxt = '0;
                end else if (r_timer == w_limit) begin
                    w_pulse_l   = r_dir;
                    w_pulse_r   = ~r_dir;
                    w_timer_nxt = '0;
                    w_state_nxt = REPEAT;
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end
            end
            LOCKED: begin
                w_timer_nxt = '0;
                if (!w_db_nxt[CH_L] && !w_db_nxt[CH_R])
                    w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dir      <= 1'b0;
            r_timer    <= '0;
            move_right <= 1'b0;
            move_left  <= 1'b0;
            drop_piece <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_timer    <= w_timer_nxt;
            move_right <= w_pulse_r;
            move_left  <= w_pulse_l;
            drop_piece <= w_rise[CH_D];
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a window/elapsed-time model.

module tb_button_conditioner;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_n;
    logic r0, l0, d0, r1, l1, d1;
    logic mr0, ml0, dp0, mr1, ml1, dp1;

    button_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                         .CNT_W(8), .ACTIVE_LOW(1'b0)) u_dut0 (
        .clk_25MHz(clk), .rst_n(rst_n),
        .btn_right_raw(r0), .btn_left_raw(l0), .btn_drop_raw(d0),
        .move_right(mr0), .move_left(ml0), .drop_piece(dp0));

    button_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                         .CNT_W(8), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk_25MHz(clk), .rst_n(rst_n),
        .btn_right_raw(r1), .btn_left_raw(l1), .btn_drop_raw(d1),
        .move_right(mr1), .move_left(ml1), .drop_piece(dp1));

    int checks = 0;
    int errors = 0;
    int cyc    = -1;

    // Model: raw history, a window of the last DEB synchronized samples,
    // and elapsed edges since the first pulse of the held direction.
    logic           h0  [2][3];
    logic           h1  [2][3];
    logic           db  [2][3];
    logic [DEB-1:0] win [2][3];
    int             mode[2];     // 0 idle, 1 active, 2 locked
    logic           dir [2];     // 1 = left
    int             st  [2];
    logic [2:0]     expv[2];     // {drop, left, right}

    int lr0[$], ll0[$], ld0[$], lm1[$], ld1[$];
    int ex[8];

    task automatic model_reset(input int i);
        for (int c = 0; c < 3; c++) begin
            h0[i][c] = 1'b0; h1[i][c] = 1'b0; db[i][c] = 1'b0; win[i][c] = '0;
        end
        mode[i] = 0; dir[i] = 1'b0; st[i] = 0; expv[i] = 3'b000;
    endtask

    task automatic model_step(input int i, input logic [2:0] raw);
        logic [2:0] nx, rise;
        logic pl, pr, s2p;
        int e;
        for (int c = 0; c < 3; c++) begin
            s2p = h1[i][c];
            h1[i][c] = h0[i][c];
            h0[i][c] = raw[c];
            win[i][c] = {win[i][c][DEB-2:0], s2p};
            nx[c] = db[i][c];
            if (!db[i][c] && win[i][c] == {DEB{1'b1}}) nx[c] = 1'b1;
            else if (db[i][c] && win[i][c] == '0)     nx[c] = 1'b0;
            rise[c] = nx[c] & ~db[i][c];
            db[i][c] = nx[c];
        end
        pl = 1'b0; pr = 1'b0;
        case (mode[i])
            0: begin
                if (nx[1] && nx[0]) mode[i] = 2;
                else if (rise[1]) begin pl = 1'b1; dir[i] = 1'b1; st[i] = cyc; mode[i] = 1; end
                else if (rise[0]) begin pr = 1'b1; dir[i] = 1'b0; st[i] = cyc; mode[i] = 1; end
            end
            1: begin
                if (!(dir[i] ? nx[1] : nx[0])) mode[i] = 0;
                else if (dir[i] ? nx[0] : nx[1]) mode[i] = 2;
                else begin
                    e = cyc - st[i];
                    if (e == RD || (e > RD && (e - RD) % RP == 0)) begin
                        pl = dir[i]; pr = ~dir[i];
                    end
                end
            end
            default: if (!nx[1] && !nx[0]) mode[i] = 0;
        endcase
        expv[i] = {rise[2], pl, pr};
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, {d0, l0, r0});
            model_step(1, ~{d1, l1, r1});
            if (expv[0][0]) lr0.push_back(cyc);
            if (expv[0][1]) ll0.push_back(cyc);
            if (expv[0][2]) ld0.push_back(cyc);
            if (expv[1][0] || expv[1][1]) lm1.push_back(cyc);
            if (expv[1][2]) ld1.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        #1;
        checks++;
        if ({dp0, ml0, mr0} !== expv[0]) begin
            errors++;
            $display("FAIL out0 edge %0d got {drop,left,right}=%b want %b", cyc, {dp0, ml0, mr0}, expv[0]);
        end
        checks++;
        if ({dp1, ml1, mr1} !== expv[1]) begin
            errors++;
            $display("FAIL out1 edge %0d got {drop,left,right}=%b want %b", cyc, {dp1, ml1, mr1}, expv[1]);
        end
    end

    task automatic clear_logs();
        lr0.delete(); ll0.delete(); ld0.delete(); lm1.delete(); ld1.delete();
    endtask

    task automatic set_ex(input int a0, input int a1, input int a2, input int a3,
                          input int a4, input int a5, input int a6);
        ex[0] = a0; ex[1] = a1; ex[2] = a2; ex[3] = a3;
        ex[4] = a4; ex[5] = a5; ex[6] = a6; ex[7] = -1;
    endtask

    task automatic check_q(input string nm, input int sel, input int t0);
        int q[$];
        int n;
        bit ok;
        string sg, sw;
        case (sel)
            0: q = lr0;
            1: q = ll0;
            2: q = ld0;
            3: q = lm1;
            default: q = ld1;
        endcase
        n = 0; sw = "";
        for (int k = 0; k < 8; k++)
            if (ex[k] >= 0) begin n++; sw = {sw, $sformatf(" %0d", ex[k])}; end
        ok = (q.size() == n);
        sg = "";
        for (int k = 0; k < q.size(); k++) begin
            if (ok && (q[k] - t0) != ex[k]) ok = 1'b0;
            if (k < 16) sg = {sg, $sformatf(" %0d", q[k] - t0)};
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s pulse edges got [%s ] want [%s ]", nm, sg, sw);
        end
    endtask

    task automatic idle(input int n);
        r0 = 1'b0; l0 = 1'b0; d0 = 1'b0;
        r1 = 1'b1; l1 = 1'b1; d1 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int t0;
    int cd[2][3];
    logic v[2][3];
    int rc;

    initial begin
        rst_n = 1'b0;
        r0 = 1'b0; l0 = 1'b0; d0 = 1'b0;
        r1 = 1'b1; l1 = 1'b1; d1 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // Right held 10 cycles.
        clear_logs(); t0 = cyc + 1;
        for (int e = 0; e < 40; e++) begin r0 = (e < 10); @(negedge clk); end
        set_ex(5, -1, -1, -1, -1, -1, -1); check_q("t1_right", 0, t0);
        set_ex(-1, -1, -1, -1, -1, -1, -1); check_q("t1_left", 1, t0);
        idle(10);

        // Bounce: 3 high / 1 low never reaches DEB consecutive samples.
        clear_logs(); t0 = cyc + 1;
        for (int e = 0; e < 60; e++) begin r0 = (e < 40) && (e % 4 != 3); @(negedge clk); end
        set_ex(-1, -1, -1, -1, -1, -1, -1); check_q("t2_bounce_right", 0, t0);
        idle(10);

        // Left held 58 cycles, then a fresh press proves the FSM returned to idle.
        clear_logs(); t0 = cyc + 1;
        for (int e = 0; e < 100; e++) begin l0 = (e < 58) || (e >= 70 && e < 80); @(negedge clk); end
        set_ex(5, 25, 33, 41, 49, 57, 75); check_q("t3_left_repeat", 1, t0);
        set_ex(-1, -1, -1, -1, -1, -1, -1); check_q("t3_right", 0, t0);
        idle(10);

        // Right then left: lockout.
        clear_logs(); t0 = cyc + 1;
        for (int e = 0; e < 90; e++) begin r0 = (e < 60); l0 = (e >= 10 && e < 40); @(negedge clk); end
        set_ex(5, -1, -1, -1, -1, -1, -1); check_q("t4_right_lock", 0, t0);
        set_ex(-1, -1, -1, -1, -1, -1, -1); check_q("t4_left_lock", 1, t0);
        idle(10);

        // Active-low drop on the second instance.
        clear_logs(); t0 = cyc + 1;
        for (int e = 0; e < 120; e++) begin d1 = !(e < 100); @(negedge clk); end
        set_ex(5, -1, -1, -1, -1, -1, -1); check_q("t5_drop_al", 4, t0);
        set_ex(-1, -1, -1, -1, -1, -1, -1); check_q("t5_moves_al", 3, t0);
        check_q("t5_drop_inst0", 2, t0);
        idle(10);

        // Reset mid-hold.
        clear_logs(); t0 = cyc + 1;
        for (int e = 0; e < 100; e++) begin
            l0 = (e < 80);
            rst_n = !(e >= 30 && e < 33);
            @(negedge clk);
        end
        rst_n = 1'b1;
        set_ex(5, 25, 38, 58, 66, 74, 82); check_q("t6_reset_left", 1, t0);
        idle(10);

        // Randomized run lengths mixing bounce, long holds and short resets.
        rc = 0;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 3; c++) begin cd[i][c] = 0; v[i][c] = (i == 1); end
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < 3; c++) begin
                    if (cd[i][c] == 0) begin
                        v[i][c]  = 1'($urandom_range(0, 1));
                        cd[i][c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5))
                                                                : int'($urandom_range(6, 60));
                    end else begin
                        cd[i][c]--;
                    end
                end
            r0 = v[0][0]; l0 = v[0][1]; d0 = v[0][2];
            r1 = v[1][0]; l1 = v[1][1]; d1 = v[1][2];
            if (rc == 0 && $urandom_range(0, 799) == 0) rc = int'($urandom_range(1, 3));
            rst_n = (rc == 0);
            if (rc > 0) rc--;
            @(negedge clk);
        end
        rst_n = 1'b1;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end input stage for the game logic. Takes three raw, asynchronous, bouncing push-button signals (right, left, drop).
- Produces clean single-cycle command pulses move_right, move_left and drop_piece in the clk_25MHz domain.
- Adds a 2-flop synchronizer, a per-channel debounce filter, rising-edge pulse generation, and hold-to-auto-repeat for left/right with mutual lockout.
- Outputs connect directly to the game engine's move_right/move_left/drop_piece inputs.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive cycles of changed input required before the debounced state flips (10 ms at 25 MHz); must be >= 2.
- REPEAT_DELAY, 12500000, hold cycles after the initial left/right pulse before the first repeat pulse (500 ms).
- REPEAT_PERIOD, 3750000, cycles between subsequent repeat pulses (150 ms).
- CNT_W, 24, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- ACTIVE_LOW, 0, if 1 the raw buttons are inverted at the input (pressed = 0).

Ports:
- clk_25MHz, input, 1, pixel/system clock.
- rst_n, input, 1, asynchronous active-low reset.
- btn_right_raw, input, 1, raw right button, asynchronous.
- btn_left_raw, input, 1, raw left button, asynchronous.
- btn_drop_raw, input, 1, raw drop button, asynchronous.
- move_right, output, 1, one-cycle move-right command, registered.
- move_left, output, 1, one-cycle move-left command, registered.
- drop_piece, output, 1, one-cycle drop command, registered.

Behaviour:
- Reset (already decided): one clock, clk_25MHz; reset rst_n is asynchronous, active-low. While rst_n = 0, every flop clears to 0:
  - sync stages, debounced states, counters, FSM state IDLE;
  - all outputs 0.
- Input and synchronizer:
  - Each raw input is XORed with ACTIVE_LOW.
  - It then passes through two flops (s1, s2).
- Debounce, per channel:
  - State db and counter cnt.
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Debounce latency and glitch rejection:
  - A clean press first sampled into s1 at edge k flips db at edge k+1+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES never flips db.
- Drop channel:
  - drop_piece = 1 for exactly one cycle, registered on the same edge db_drop goes 0->1.
  - No auto-repeat; release produces nothing.
- Left/right FSM, states IDLE, DELAY, REPEAT, LOCKED; one shared timer.
- IDLE:
  - On the edge where exactly one of db_left/db_right rises while the other is 0: pulse that direction, clear timer, go to DELAY.
  - If both are high (or both rise together): go to LOCKED, no pulse.
- DELAY:
  - timer increments each cycle.
  - On the edge where timer == REPEAT_DELAY-1 and the direction is still held: pulse, clear timer, go to REPEAT.
- REPEAT:
  - The same rule applies with REPEAT_PERIOD-1; the FSM stays in REPEAT.
- Release in DELAY or REPEAT:
  - Held direction's db returns to 0: go to IDLE, no pulse, timer cleared.
- Opposite direction in DELAY or REPEAT:
  - The opposite db rises: go to LOCKED, no pulse.
- LOCKED:
  - No left/right pulses.
  - Go to IDLE only when both db_left and db_right are 0. A direction still held after the other is released is ignored until released and pressed again.
- Pulse timing: the first pulse appears DEBOUNCE_CYCLES+1 edges after the first sampling edge. Repeat pulses follow at +REPEAT_DELAY, then every +REPEAT_PERIOD edges.
- Invariants:
  - move_left and move_right are never high in the same cycle.
  - Each output is high for at most one cycle at a time.
  - drop_piece is independent of the left/right FSM and may coincide with a move pulse.
- Reset mid-operation:
  - Outputs drop to 0 immediately.
  - A button held through reset release is treated as a fresh press and pulses DEBOUNCE_CYCLES+1 edges after the first post-reset sampling edge.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; edge 0 = first edge sampling raw high):
- Right held 10 cycles then released -> exactly one move_right pulse, at edge 5; nothing at release.
- Right toggling high 3 cycles / low 1 cycle for 40 cycles (bounce), then steady 0 -> no move_right pulse.
- Left held 58 cycles -> move_left pulses at edges 5, 25, 33, 41, 49, 57 only; FSM IDLE after db_left falls (edge 63).
- Right held from edge 0; left pressed at edge 10 and held; left released at 40, right released at 60 -> right pulse at 5 only; no pulses from 15 onward; IDLE after both release.
- Drop held 100 cycles, with ACTIVE_LOW=1 and the raw line driven 0 -> exactly one drop_piece pulse, at edge 5.
- Left held; rst_n asserted at edge 30 for 3 cycles while left stays held -> outputs 0 during reset; fresh move_left pulse 5 edges after the first post-reset sampling edge, then repeats resume from that point.
